hs_sender: RTL and testbench

Parametrised CPU-side transmitter for the four-phase send/ack link to the peripheral FSM. It buffers CPU words in a small FIFO and drives each word onto the transfer bus with a registered `send` request. It synchronises the peripheral's `ack` into the local clock domain. It generalises the fixed 2-bit single-word CPU FSM to configurable width and depth, with back-pressure, a completion pulse and an optional handshake watchdog.

---
 rtl/hs_sender.sv | 163 ++++++++++++++++
 tb/tb_hs_sender.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_sender.sv
`default_nettype none
// ============================================================================
// Module   : hs_sender
// Purpose  : CPU-side transmitter for a four-phase send/ack link. CPU words
//            are buffered in a power-of-two FIFO. Each word is driven onto
//            dadoT with a registered send request. The peripheral's
//            asynchronous ack is synchronised before the FSM uses it.
// Ports    : clock, reset (async active-low)
//            in_valid/dadoCPU/in_ready : CPU push interface
//            send/dadoT                : request and transfer data (registered)
//            ack                       : asynchronous peripheral acknowledge
//            done                      : one-cycle handshake-complete pulse
//            count                     : FIFO occupancy
//            err/err_clr               : sticky watchdog flag and its clear
// Option   : define HS_TIMEOUT_EN to enable the handshake watchdog
//            (TIMEOUT_CYC cycles in REQ or RELEASE abort the transfer).
// Revision : 1.0 - initial release
// ============================================================================
module hs_sender #(
  parameter int DATA_W      = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            dadoCPU,
  output logic                         in_ready,
  output logic                         send,
  output logic [DATA_W-1:0]            dadoT,
  input  logic                         ack,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err,
  input  logic                         err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    push, pop;
  logic [SYNC_STAGES-1:0]  ack_sync;
  logic                    ack_s;
  logic                    send_n, done_n;
  logic                    timeout;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign ack_s    = ack_sync[SYNC_STAGES-1];

  // ack crosses clock domains: only the last stage feeds the FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= dadoCPU;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state logic. send/done are computed here and registered below so
  // that both outputs are glitch-free flops.
  always_comb begin
    state_n = state;
    send_n  = 1'b0;
    done_n  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          send_n  = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (timeout)    state_n = IDLE;
        else if (ack_s) state_n = RELEASE;
        else            send_n  = 1'b1;
      end
      RELEASE: begin
        if (timeout) begin
          state_n = IDLE;
        end else if (!ack_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      send  <= 1'b0;
      done  <= 1'b0;
      dadoT <= '0;
    end else begin
      state <= state_n;
      send  <= send_n;
      done  <= done_n;
      // dadoT only moves when a word is popped on entry to REQ.
      if (pop) dadoT <= mem[rd_ptr];
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] tcnt;

  // tcnt holds the number of completed cycles spent in the current state,
  // so the abort edge is the TIMEOUT_CYC-th edge after entry.
  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC-1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 tcnt <= '0;
    else if (state_n != state)  tcnt <= '0;
    else if (state != IDLE)     tcnt <= tcnt + TW'(1);
  end

  // A fresh timeout takes priority over a clear on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       err <= 1'b0;
    else if (timeout) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
  wire   unused_cfg = err_clr ^ (TIMEOUT_CYC > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_sender
// Purpose  : Self-checking bench for hs_sender (DATA_W=2, DEPTH=4,
//            SYNC_STAGES=2, TIMEOUT_CYC=8). Table-driven single handshake
//            plus directed multi-cycle sequences. The watchdog part follows
//            HS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_sender;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] dadoCPU;
  logic       in_ready;
  logic       send;
  logic [1:0] dadoT;
  logic       ack;
  logic       done;
  logic [2:0] count;
  logic       err;
  logic       err_clr;

  logic       man_ack;
  logic       auto_mode;
  logic       pe1, pe2;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  logic [1:0] sent_q[$];
  logic [1:0] exp_q[$];

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       a;
    logic       s;
    logic [1:0] t;
    logic [2:0] c;
    logic       r;
    logic       dn;
  } vec_t;
  vec_t tbl[9];

  hs_sender #(
    .DATA_W(2), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(8)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .dadoCPU(dadoCPU),
    .in_ready(in_ready), .send(send), .dadoT(dadoT), .ack(ack),
    .done(done), .count(count), .err(err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  assign ack = auto_mode ? pe2 : man_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_send(input logic v, input int bound, input string name);
    int n = 0;
    while (send !== v && n < bound) begin
      step();
      n++;
    end
    chk(name, send, v);
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk(name, done, 1'b1);
  endtask

  // Peripheral model: ack echoes send two cycles later.
  initial begin
    pe1 = 1'b0;
    pe2 = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!auto_mode) begin
        pe1 = 1'b0;
        pe2 = 1'b0;
      end else begin
        pe2 = pe1;
        pe1 = send;
      end
    end
  end

  // Monitor: counts done pulses, logs dadoT at each send rise, checks
  // in_ready against count and that dadoT moves only on entry to REQ.
  initial begin
    logic       sp;
    logic [1:0] tp;
    logic       pv;
    sp = 1'b0;
    tp = 2'b00;
    pv = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        pv = 1'b0;
        sp = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (send && !sp) sent_q.push_back(dadoT);
        chk("in_ready_vs_count", in_ready, (count < 3'd4));
        if (pv && dadoT != tp) chk("dadoT_change_only_at_send_rise", {send, sp}, 2'b10);
        sp = send;
        tp = dadoT;
        pv = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int base;
    int n;
    logic [1:0] nv;
    logic [1:0] fill_vals[5];

    reset     = 1'b0;
    in_valid  = 1'b0;
    dadoCPU   = 2'b00;
    man_ack   = 1'b0;
    auto_mode = 1'b0;
    err_clr   = 1'b0;

    // Single handshake with a hand-driven ack, one row per clock edge.
    //           v     d      a     send  dadoT  count  rdy   done
    tbl[0] = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 3'd1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 3'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 3'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 3'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0};

    // Reset
    repeat (10) step();
    reset = 1'b1;
    chk("rst_send", send, 1'b0);
    chk("rst_dadoT", dadoT, 2'd0);
    chk("rst_count", count, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    step();

    // Table-driven handshake
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].v;
      dadoCPU  = tbl[i].d;
      man_ack  = tbl[i].a;
      step();
      chk($sformatf("row%0d_send", i), send, tbl[i].s);
      chk($sformatf("row%0d_dadoT", i), dadoT, tbl[i].t);
      chk($sformatf("row%0d_count", i), count, tbl[i].c);
      chk($sformatf("row%0d_in_ready", i), in_ready, tbl[i].r);
      chk($sformatf("row%0d_done", i), done, tbl[i].dn);
    end

    // Single word with an echoing peripheral
    auto_mode = 1'b1;
    step();
    base = done_cnt;
    sent_q.delete();
    in_valid = 1'b1;
    dadoCPU  = 2'b01;
    step();
    in_valid = 1'b0;
    chk("echo_count_after_push", count, 3'd1);
    chk("echo_send_low_at_push", send, 1'b0);
    step();
    chk("echo_send_rise", send, 1'b1);
    chk("echo_dadoT", dadoT, 2'd1);
    wait_done(30, "echo_done_seen");
    repeat (4) step();
    chk("echo_done_pulses", done_cnt - base, 1);
    chk("echo_count_end", count, 3'd0);
    chk("echo_sent_words", sent_q.size(), 1);
    if (sent_q.size() > 0) chk("echo_sent_word0", sent_q[0], 2'd1);

    // Fill and drain
    auto_mode = 1'b0;
    step();
    step();
    base = done_cnt;
    sent_q.delete();
    fill_vals[0] = 2'd1; fill_vals[1] = 2'd0; fill_vals[2] = 2'd1;
    fill_vals[3] = 2'd2; fill_vals[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dadoCPU  = fill_vals[i];
      n = 0;
      while (!in_ready && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("fill%0d_ready", i), in_ready, 1'b1);
      step();
    end
    chk("fill_count_full", count, 3'd4);
    chk("fill_in_ready_low", in_ready, 1'b0);
    dadoCPU = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("full_hold%0d_count", i), count, 3'd4);
    end
    in_valid  = 1'b0;
    auto_mode = 1'b1;
    n = 0;
    while (done_cnt - base < 5 && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("drain_done_pulses", done_cnt - base, 5);
    chk("drain_count", count, 3'd0);
    chk("drain_sent_words", sent_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < sent_q.size()) chk($sformatf("drain_word%0d", i), sent_q[i], fill_vals[i]);

    // Simultaneous push and pop, three passes around the FIFO
    step();
    auto_mode = 1'b0;
    step();
    step();
    exp_q.delete();
    in_valid = 1'b1;
    dadoCPU  = 2'd0; step();
    dadoCPU  = 2'd1; step();
    dadoCPU  = 2'd2; step();
    in_valid = 1'b0;
    chk("pp_pre_count", count, 3'd2);
    chk("pp_pre_send", send, 1'b1);
    chk("pp_pre_dadoT", dadoT, 2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    for (int k = 0; k < 12; k++) begin
      man_ack = 1'b1;
      wait_send(1'b0, 10, $sformatf("pp%0d_send_fall", k));
      man_ack = 1'b0;
      wait_done(10, $sformatf("pp%0d_done", k));
      nv = 2'((k + 3) % 4);
      in_valid = 1'b1;
      dadoCPU  = nv;
      step();
      in_valid = 1'b0;
      chk($sformatf("pp%0d_send", k), send, 1'b1);
      chk($sformatf("pp%0d_count", k), count, 3'd2);
      chk($sformatf("pp%0d_dadoT", k), dadoT, exp_q.pop_front());
      exp_q.push_back(nv);
    end

    // Reset mid-handshake
    in_valid = 1'b1;
    dadoCPU  = 2'd3;
    step();
    in_valid = 1'b0;
    chk("mid_pre_count", count, 3'd3);
    chk("mid_pre_send", send, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_send_async", send, 1'b0);
    chk("mid_count_async", count, 3'd0);
    chk("mid_in_ready_async", in_ready, 1'b1);
    chk("mid_dadoT_async", dadoT, 2'd0);
    step();
    #3;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post_rst%0d_send", i), send, 1'b0);
      chk($sformatf("post_rst%0d_count", i), count, 3'd0);
    end

`ifdef HS_TIMEOUT_EN
    // Watchdog: ack stuck low
    base = done_cnt;
    in_valid = 1'b1;
    dadoCPU  = 2'd3; step();
    dadoCPU  = 2'd2; step();
    in_valid = 1'b0;
    chk("to_send_start", send, 1'b1);
    chk("to_dadoT0", dadoT, 2'd3);
    n = 0;
    while (send && n < 50) begin
      step();
      n++;
    end
    chk("to_req_cycles", n, 8);
    chk("to_err_set", err, 1'b1);
    step();
    chk("to_next_send", send, 1'b1);
    chk("to_next_dadoT", dadoT, 2'd2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_cleared", err, 1'b0);
    step();
    err_clr = 1'b1;
    n = 0;
    while (send && n < 50) begin
      step();
      n++;
    end
    err_clr = 1'b0;
    chk("to_new_timeout_wins", err, 1'b1);
    chk("to_second_send_low", send, 1'b0);
    step();
    chk("to_err_sticky", err, 1'b1);
    chk("to_count_empty", count, 3'd0);
    chk("to_no_done", done_cnt - base, 0);
`else
    // No watchdog: the FSM waits indefinitely and err stays low
    base = done_cnt;
    in_valid = 1'b1;
    dadoCPU  = 2'd3;
    step();
    in_valid = 1'b0;
    step();
    chk("nto_send_start", send, 1'b1);
    for (int i = 0; i < 100; i++) begin
      err_clr = (i % 7 == 0);
      step();
    end
    err_clr = 1'b0;
    chk("nto_send_held", send, 1'b1);
    chk("nto_dadoT", dadoT, 2'd3);
    chk("nto_err_low", err, 1'b0);
    chk("nto_no_done", done_cnt - base, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
